multicycle_control: RTL
=======================

# multicycle_control

Multicycle sequencing controller for the MIPS datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back, driving the shared ALU, memory and register-file selects cycle by cycle. It replaces the single-cycle main decoder when the datapath runs multicycle with one memory port and one ALU. It supports R-type, lw, sw, beq and j, and inserts memory wait states through a ready handshake.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- opCode  input  6  instruction bits [31:26] from the instruction register
- mem_ready  input  1  memory has completed the current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls
- ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  output  2  00 add, 01 sub (beq), 10 funct-decoded
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal_op  output  1  one-cycle pulse, unknown opcode in DECODE
- retired  output  1  one-cycle pulse on an instruction's final cycle
- state  output  4  current state code, debug

## Operation
- States (codes): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9. Codes 10-15 unreachable; if entered, next state is FETCH with all outputs 0.
- Outputs decode from the state register, plus mem_ready where noted. Any control not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Go to DECODE if mem_ready, else hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target to ALUOut). Next state by opCode:
  - 100011 or 101011 -> MEM_ADDR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - other -> FETCH, with illegal_op=1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, retired=1. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1, retired=mem_ready. Hold until mem_ready, then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALU_WB.
- ALU_WB: RegDst=1, RegWrite=1, MemtoReg=0, retired=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, retired=1. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10, retired=1. Go to FETCH.
- opCode is sampled in DECODE and MEM_ADDR only. It must be stable from the cycle after IRWrite until the instruction retires.

## Timing
- While reset=1, every output is 0, including state. State becomes FETCH at the edge. The first cycle after reset deasserts shows FETCH outputs.
- Reset asserted mid-instruction aborts it at the next edge. No retired pulse for the aborted instruction, and no further writes after that edge.
- Cycle counts with zero-wait memory (mem_ready held 1):
  - lw 5, R-type 4, sw 4, beq 3, j 3
  - illegal opcode 2 (FETCH, DECODE)
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. All outputs hold constant while waiting.
- mem_ready is ignored in all other states.
- retired and illegal_op are never asserted in the same cycle.

## Structure
- Shared package (mips_pkg):
  - state codes
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - ALUOp, ALUSrcB and PCSource encodings
- One sub-module, multicycle_control_outputs: purely combinational state+mem_ready -> control-vector decoder.
- The top level keeps the state register and next-state logic.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1: all outputs 0 during reset; next cycle state=0, MemRead=1, IRWrite=1, PCWrite=1.
- lw (100011), mem_ready=1: states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 only in state 4; retired once, on the 5th cycle.
- sw (101011), mem_ready low 2 cycles in MEM_WRITE: state 5 lasts 3 cycles with MemWrite=1 and IorD=1 throughout; retired only on the last of them.
- beq (000100) then j (000010): BRANCH shows PCWriteCond=1, ALUOp=01, PCSource=01; JUMP shows PCWrite=1, PCSource=10; each instruction takes 3 cycles.
- Opcode 111111: illegal_op=1 in DECODE, back to FETCH next cycle, no RegWrite or MemWrite ever asserted.
- reset asserted during MEM_READ: next cycle all outputs 0; after release, state=FETCH and no MEM_WB occurs.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS controller: FSM state codes,
// opcode constants, datapath select encodings and the control-vector struct
// produced by the output decoder.
// ---------------------------------------------------------------------------
package mips_pkg;

   // State codes are visible on the debug port, so their values are fixed.
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9
   } state_t;

   // Instruction opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALUOp encodings
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PCSource encodings
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Datapath control vector for one cycle
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       alu_src_a;
      logic       reg_write;
      logic       reg_dst;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       retired;
   } ctrl_t;

   // True for the five opcodes the controller can sequence
   function automatic logic is_legal_op(input logic [5:0] op);
      logic legal;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
         default:                              legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/multicycle_control_outputs.sv
// ---------------------------------------------------------------------------
// multicycle_control_outputs
// Combinational Moore decoder: current state (+ mem_ready for the wait-state
// controls) to the datapath control vector.
// Ports:
//   state_i      current state register value (4 bits, may hold 10-15)
//   mem_ready_i  memory completed its access this cycle
//   ctrl_o       control vector for this cycle
// ---------------------------------------------------------------------------
module multicycle_control_outputs
   import mips_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic       mem_ready_i,
   output ctrl_t      ctrl_o
);

   // Per-state control decode; anything not set stays 0
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.alu_op    = ALUOP_ADD;
            ctrl_o.pc_source = PCSRC_ALU;
            // IR and PC update only on the cycle the fetch completes
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         S_DECODE: begin
            // Speculative branch target PC+4 + (imm<<2) into ALUOut
            ctrl_o.alu_src_b = SRCB_IMM_SH2;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEM_ADDR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEM_READ: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.retired    = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.i_or_d    = 1'b1;
            ctrl_o.retired   = mem_ready_i;
         end
         S_EXECUTE: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_REGB;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            ctrl_o.reg_dst   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.retired   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = SRCB_REGB;
            ctrl_o.alu_op        = ALUOP_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
            ctrl_o.retired       = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCSRC_JUMP;
            ctrl_o.retired   = 1'b1;
         end
         default: begin
            // Unreachable codes 10-15: everything deasserted
            ctrl_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multicycle MIPS sequencing controller (Moore FSM). Steps R-type, lw, sw,
// beq and j through fetch/decode/execute/memory/write-back, stretching
// FETCH, MEM_READ and MEM_WRITE until mem_ready.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   opCode             instruction[31:26] from the instruction register
//   mem_ready          memory access completes this cycle
//   PCWrite..RegDst    1-bit datapath controls
//   ALUSrcB, ALUOp, PCSource   2-bit datapath selects
//   illegal_op         pulse: unknown opcode seen in DECODE
//   retired            pulse: final cycle of an instruction
//   state              current state code (debug)
// ---------------------------------------------------------------------------
module multicycle_control
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opCode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal_op,
   output logic       retired,
   output logic [3:0] state
);

   logic [3:0] state_q;
   logic [3:0] state_d;
   ctrl_t      ctrl;
   logic       illegal_d;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = S_FETCH;
      illegal_d = 1'b0;
      case (state_q)
         S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opCode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
            illegal_d = ~is_legal_op(opCode);
         end
         S_MEM_ADDR: begin
            if (opCode == OP_LW) begin
               state_d = S_MEM_READ;
            end else if (opCode == OP_SW) begin
               state_d = S_MEM_WRITE;
            end else begin
               // opCode changed under us; recover cleanly
               state_d = S_FETCH;
            end
         end
         S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_EXECUTE:   state_d = S_ALU_WB;
         S_ALU_WB:    state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         default:     state_d = S_FETCH;
      endcase
   end

   multicycle_control_outputs u_outputs (
      .state_i     (state_q),
      .mem_ready_i (mem_ready),
      .ctrl_o      (ctrl)
   );

   // Output drive; reset forces everything low in the same cycle, so an
   // aborted instruction cannot issue a write while reset is high
   always_comb begin
      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         MemtoReg    = 1'b0;
         IRWrite     = 1'b0;
         ALUSrcA     = 1'b0;
         RegWrite    = 1'b0;
         RegDst      = 1'b0;
         ALUSrcB     = 2'b00;
         ALUOp       = 2'b00;
         PCSource    = 2'b00;
         illegal_op  = 1'b0;
         retired     = 1'b0;
         state       = 4'd0;
      end else begin
         PCWrite     = ctrl.pc_write;
         PCWriteCond = ctrl.pc_write_cond;
         IorD        = ctrl.i_or_d;
         MemRead     = ctrl.mem_read;
         MemWrite    = ctrl.mem_write;
         MemtoReg    = ctrl.mem_to_reg;
         IRWrite     = ctrl.ir_write;
         ALUSrcA     = ctrl.alu_src_a;
         RegWrite    = ctrl.reg_write;
         RegDst      = ctrl.reg_dst;
         ALUSrcB     = ctrl.alu_src_b;
         ALUOp       = ctrl.alu_op;
         PCSource    = ctrl.pc_source;
         illegal_op  = illegal_d;
         retired     = ctrl.retired;
         state       = state_q;
      end
   end

endmodule
